// File: rtl/gsim_job_arbiter_if.sv
// Signal bundle between the two job requesters, the GSIM core and the response
// consumer; the arbiter connects through the slave modport.
interface gsim_job_arbiter_if #(
  parameter int AW = 512,
  parameter int BW = 64,
  parameter int XW = 256
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_a;
  logic [BW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_a;
  logic [BW-1:0] req1_b;
  logic          core_start;
  logic          core_rst;
  logic [AW-1:0] core_a;
  logic [BW-1:0] core_b;
  logic          core_done;
  logic [XW-1:0] core_x;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic          rsp_err;
  logic [XW-1:0] rsp_x;
  logic          busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  core_done, core_x, rsp_ready,
    output req0_ready, req1_ready,
    output core_start, core_rst, core_a, core_b,
    output rsp_valid, rsp_id, rsp_err, rsp_x, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output core_done, core_x, rsp_ready,
    input  req0_ready, req1_ready,
    input  core_start, core_rst, core_a, core_b,
    input  rsp_valid, rsp_id, rsp_err, rsp_x, busy
  );
endinterface

// File: rtl/gsim_job_arbiter.sv
// Round-robin sharing of one GSIM solver core between two requesters:
// grant, launch, wait for done or timeout, return tagged result, clear core.
module gsim_job_arbiter #(
  parameter int AW      = 512,
  parameter int BW      = 64,
  parameter int XW      = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  gsim_job_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic          r_last_grant;
  logic          r_id;
  logic          r_rsp_err;
  logic [15:0]   r_timer;
  logic [AW-1:0] r_core_a;
  logic [BW-1:0] r_core_b;
  logic [XW-1:0] r_rsp_x;

  logic w_grant0;
  logic w_grant1;
  logic w_idle;

  // On a tie the requester that did not win last time gets the core.
  always_comb begin
    w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    w_idle   = (r_state == S_IDLE);
  end

  // Control outputs are masked while reset is held so nothing leaks during it.
  assign bus.req0_ready = !reset && w_idle && w_grant0;
  assign bus.req1_ready = !reset && w_idle && w_grant1;
  assign bus.core_start = !reset && (r_state == S_LAUNCH);
  assign bus.core_rst   = reset || (r_state == S_CLEAR);
  assign bus.rsp_valid  = !reset && (r_state == S_RESP);
  assign bus.busy       = !reset && !w_idle;
  assign bus.core_a     = r_core_a;
  assign bus.core_b     = r_core_b;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_x      = r_rsp_x;

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_timer      <= '0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_rsp_x      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_core_a     <= w_grant1 ? bus.req1_a : bus.req0_a;
            r_core_b     <= w_grant1 ? bus.req1_b : bus.req0_b;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done strobe in the final timeout cycle still counts as success.
          if (bus.core_done) begin
            r_rsp_x   <= bus.core_x;
            r_rsp_err <= 1'b0;
            r_state   <= S_RESP;
          end else if (r_timer == TMO_LAST) begin
            r_rsp_x   <= '0;
            r_rsp_err <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_CLEAR;
        end
        S_CLEAR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gsim_job_arbiter.md
Name: gsim_job_arbiter

Overview:
- Shares one Gauss-Seidel solver core (GSIM) between two independent requesters.
- Arbitrates jobs round-robin and launches the core with a one-cycle start pulse.
- Waits for the core's done strobe or a timeout, returns the solution tagged with the requester ID, then clears the core before the next job.
- Sits between the input-loading front ends and the GSIM datapath.

Parameters:
AW, 512, width of packed coefficient matrix A (32 x 16-bit words).
BW, 64, width of packed right-hand-side vector b.
XW, 256, width of packed solution vector x (8 x 32-bit).
TIMEOUT, 1024, max WAIT cycles before a job is aborted (>=2, <=65535).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
req0_valid  in  1  requester 0 has a job.
req0_ready  out  1  requester 0 job accepted this cycle.
req0_a  in  AW  requester 0 matrix A.
req0_b  in  BW  requester 0 vector b.
req1_valid  in  1  requester 1 has a job.
req1_ready  out  1  requester 1 job accepted this cycle.
req1_a  in  AW  requester 1 matrix A.
req1_b  in  BW  requester 1 vector b.
core_start  out  1  one-cycle launch pulse to the core.
core_rst  out  1  core clear, active-high.
core_a  out  AW  latched A to the core.
core_b  out  BW  latched b to the core.
core_done  in  1  core result valid strobe.
core_x  in  XW  core solution.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumer ready.
rsp_id  out  1  requester that owns the response.
rsp_err  out  1  1 = job timed out; rsp_x is 0.
rsp_x  out  XW  solution.
busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESP, CLEAR. Reset puts the FSM in IDLE.
- Reset values: all outputs 0 except core_rst=1 while reset is high. last_grant=1, so requester 0 wins the first tie.
- IDLE: reqN_ready is combinational and high only in IDLE for the granted requester.
  - Grant rule: if only one valid, grant it. If both valid, grant the one != last_grant.
  - On grant, in the same edge: latch reqN_a/b into core_a/core_b, set id=N, set last_grant=N, go to LAUNCH.
- LAUNCH: core_start=1 for exactly this cycle, timer cleared to 0, go to WAIT.
- WAIT: timer increments each cycle.
  - If core_done: latch rsp_x=core_x, rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_x=0, rsp_err=1, go to RESP.
  - core_done and timeout in the same cycle: done wins, err=0.
- RESP: rsp_valid=1; rsp_id, rsp_err and rsp_x are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge, go to CLEAR.
  - Backpressure is unbounded; no timeout applies in RESP.
- CLEAR: core_rst=1 for one cycle, go to IDLE. A new grant is possible in the following cycle.
- core_done outside WAIT is ignored (stale strobe).
- core_a/core_b change only on a grant and hold through WAIT.
- Latency:
  - Accept edge at T, core_start during T+1, WAIT from T+2.
  - Core done at cycle D gives rsp_valid from D+1.
  - Minimum accept-to-next-accept spacing is 5 cycles (IDLE, LAUNCH, WAIT, RESP, CLEAR), each state 1 cycle minimum.
- A requester deasserting valid before ready is legal; no job is recorded.
- Fairness: under continuous requests from both sides, grants strictly alternate.
- Reset mid-operation (any state): return to IDLE next edge, drop any in-flight job, no response, core_rst high during reset, last_grant=1.

Test Plan:
- Single job: req0 A=I(identity), b=0x0102030405060708, model core_done after 20 cycles with x=K.
  - req0_ready pulses once, core_start 1 cycle later, rsp_valid 1 cycle after done.
  - rsp_id=0, rsp_err=0, rsp_x=K, core_rst 1 cycle after handshake.
- Contention: both valid from reset, each returning 4 jobs.
  - Grant order is 0,1,0,1,0,1,0,1 and each rsp_id matches its grant.
- Timeout: TIMEOUT=16, core never done.
  - rsp_valid exactly 16 WAIT cycles after core_start, with rsp_err=1 and rsp_x=0.
  - CLEAR follows the handshake.
- Done/timeout collision: core_done on WAIT cycle TIMEOUT-1 with x=0xAA..AA → rsp_err=0, rsp_x=0xAA..AA.
- Backpressure: hold rsp_ready=0 for 10 cycles, change core_x and pulse core_done meanwhile.
  - rsp_x, rsp_id and rsp_err stay stable; no req_ready is asserted; the extra done is ignored.
- Reset in WAIT: assert reset for 1 cycle 5 cycles after core_start.
  - No rsp_valid is produced, busy=0, core_rst=1 during reset.
  - Next tie grants requester 0.
